// File: rtl/mtr_drv_pkg.sv
// Shared parameters, types and helpers for the motor H-bridge driver.
package mtr_drv_pkg;

    localparam int unsigned PWM_W       = 12;
    localparam int unsigned DEADTIME    = 32;
    localparam int unsigned OVR_I_BLANK = 40;
    localparam int unsigned OVR_I_LIMIT = 8;

    localparam int unsigned DT_W      = $clog2(DEADTIME + 1);
    localparam int unsigned OVR_CNT_W = $clog2(OVR_I_LIMIT + 1);

    typedef logic [PWM_W-1:0] duty_t;

    typedef enum logic [1:0] {
        BOTH_OFF = 2'd0,
        HI_ON    = 2'd1,
        LO_ON    = 2'd2
    } dt_state_e;

    // Offset-binary conversion: flipping the sign bit maps -2048..2047 onto 0..4095.
    function automatic duty_t spd_to_duty(input logic [PWM_W-1:0] spd);
        return {~spd[PWM_W-1], spd[PWM_W-2:0]};
    endfunction

endpackage

// File: rtl/mtr_drv_pwm_deadtime.sv
// Complementary gate generation for one H-bridge half with dead-time insertion.
module pwm_deadtime
    import mtr_drv_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic pwm_raw,
    input  logic kill,
    output logic hi,
    output logic lo
);

    dt_state_e       state_q, state_d;
    logic [DT_W-1:0] timer_q, timer_d;
    logic            raw_prev_q;
    logic            hi_q, hi_d;
    logic            lo_q, lo_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOTH_OFF;
            timer_q    <= '0;
            raw_prev_q <= 1'b0;
            hi_q       <= 1'b0;
            lo_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            raw_prev_q <= pwm_raw;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    // Any raw edge (including one during BOTH_OFF) restarts the dead-time window.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (pwm_raw != raw_prev_q) begin
            state_d = BOTH_OFF;
            timer_d = DT_W'(DEADTIME - 1);
        end else begin
            case (state_q)
                BOTH_OFF: begin
                    if (timer_q == '0) begin
                        state_d = pwm_raw ? HI_ON : LO_ON;
                    end else begin
                        timer_d = timer_q - DT_W'(1);
                    end
                end
                HI_ON, LO_ON: state_d = state_q;
                default:      state_d = BOTH_OFF;
            endcase
        end
        hi_d = (state_d == HI_ON) && !kill;
        lo_d = (state_d == LO_ON) && !kill;
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/mtr_drv.sv
// Motor driver: shadowed PWM generation, dead-time gate drive and latched over-current shutdown.
module mtr_drv
    import mtr_drv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] lft_spd,
    input  logic [PWM_W-1:0] rght_spd,
    input  logic             ovr_i_lft,
    input  logic             ovr_i_rght,
    output logic             lft_hi,
    output logic             lft_lo,
    output logic             rght_hi,
    output logic             rght_lo,
    output logic             ovr_i_shtdwn
);

    duty_t                cnt_q, cnt_d;
    duty_t                duty_lft_q, duty_lft_d;
    duty_t                duty_rght_q, duty_rght_d;
    logic                 raw_lft_q, raw_lft_d;
    logic                 raw_rght_q, raw_rght_d;
    logic [1:0]           sync_lft_q, sync_rght_q;
    logic                 period_ovr_q, period_ovr_d;
    logic [OVR_CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;
    logic                 shtdwn_q, shtdwn_d;

    logic wrap;
    logic valid_lft;
    logic valid_rght;
    logic ovr_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            duty_lft_q   <= duty_t'(12'h800);
            duty_rght_q  <= duty_t'(12'h800);
            raw_lft_q    <= 1'b0;
            raw_rght_q   <= 1'b0;
            sync_lft_q   <= '0;
            sync_rght_q  <= '0;
            period_ovr_q <= 1'b0;
            ovr_cnt_q    <= '0;
            shtdwn_q     <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            duty_lft_q   <= duty_lft_d;
            duty_rght_q  <= duty_rght_d;
            raw_lft_q    <= raw_lft_d;
            raw_rght_q   <= raw_rght_d;
            sync_lft_q   <= {sync_lft_q[0], ovr_i_lft};
            sync_rght_q  <= {sync_rght_q[0], ovr_i_rght};
            period_ovr_q <= period_ovr_d;
            ovr_cnt_q    <= ovr_cnt_d;
            shtdwn_q     <= shtdwn_d;
        end
    end

    // Over-current samples only count outside the blanking window while the high side is driven.
    always_comb begin
        wrap        = (cnt_q == '1);
        cnt_d       = cnt_q + duty_t'(1);
        duty_lft_d  = wrap ? spd_to_duty(lft_spd)  : duty_lft_q;
        duty_rght_d = wrap ? spd_to_duty(rght_spd) : duty_rght_q;
        raw_lft_d   = (cnt_q < duty_lft_q);
        raw_rght_d  = (cnt_q < duty_rght_q);

        valid_lft  = sync_lft_q[1]  && raw_lft_q  && (cnt_q >= PWM_W'(OVR_I_BLANK));
        valid_rght = sync_rght_q[1] && raw_rght_q && (cnt_q >= PWM_W'(OVR_I_BLANK));
        ovr_hit    = period_ovr_q || valid_lft || valid_rght;

        period_ovr_d = wrap ? 1'b0 : ovr_hit;
        ovr_cnt_d    = ovr_cnt_q;
        shtdwn_d     = shtdwn_q;
        if (wrap) begin
            if (ovr_hit) begin
                if (ovr_cnt_q != OVR_CNT_W'(OVR_I_LIMIT)) begin
                    ovr_cnt_d = ovr_cnt_q + OVR_CNT_W'(1);
                end
                if (ovr_cnt_q >= OVR_CNT_W'(OVR_I_LIMIT - 1)) begin
                    shtdwn_d = 1'b1;
                end
            end else begin
                ovr_cnt_d = '0;
            end
        end
    end

    // Kill uses the next shutdown value so gates drop on the same edge the latch sets.
    pwm_deadtime u_dt_lft (
        .clk     (clk),
        .rst     (rst),
        .pwm_raw (raw_lft_q),
        .kill    (shtdwn_d),
        .hi      (lft_hi),
        .lo      (lft_lo)
    );

    pwm_deadtime u_dt_rght (
        .clk     (clk),
        .rst     (rst),
        .pwm_raw (raw_rght_q),
        .kill    (shtdwn_d),
        .hi      (rght_hi),
        .lo      (rght_lo)
    );

    assign ovr_i_shtdwn = shtdwn_q;

endmodule

// File: tb/tb_mtr_drv.sv
// Directed self-checking bench for mtr_drv; samples on the falling edge, k counts rising edges since reset release.
module tb_mtr_drv;

    logic        clk;
    logic        rst;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;
    logic        ovr_i_lft;
    logic        ovr_i_rght;
    logic        lft_hi;
    logic        lft_lo;
    logic        rght_hi;
    logic        rght_lo;
    logic        ovr_i_shtdwn;

    int checks;
    int failures;

    mtr_drv dut (
        .clk          (clk),
        .rst          (rst),
        .lft_spd      (lft_spd),
        .rght_spd     (rght_spd),
        .ovr_i_lft    (ovr_i_lft),
        .ovr_i_rght   (ovr_i_rght),
        .lft_hi       (lft_hi),
        .lft_lo       (lft_lo),
        .rght_hi      (rght_hi),
        .rght_lo      (rght_lo),
        .ovr_i_shtdwn (ovr_i_shtdwn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the bench at the sample point with cnt == 0 (k = 0).
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        lft_spd = 12'h000; rght_spd = 12'h000; ovr_i_lft = 1'b0; ovr_i_rght = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({lft_hi, lft_lo, rght_hi, rght_lo, ovr_i_shtdwn} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 00000", {lft_hi, lft_lo, rght_hi, rght_lo, ovr_i_shtdwn});
        end
        rst = 1'b0;
        step();
        checks++;
        if ({lft_hi, lft_lo} !== 2'b01) begin
            failures++;
            $display("FAIL reset_k1_lo: got hi/lo %b expected 01", {lft_hi, lft_lo});
        end
        step();
        checks++;
        if ({lft_hi, lft_lo} !== 2'b00) begin
            failures++;
            $display("FAIL reset_k2_deadtime: got hi/lo %b expected 00", {lft_hi, lft_lo});
        end
        repeat (498) step();
        checks++;
        if ({lft_hi, lft_lo, rght_hi, rght_lo} !== 4'b1010) begin
            failures++;
            $display("FAIL midperiod_gates: got %b expected 1010", {lft_hi, lft_lo, rght_hi, rght_lo});
        end
        rst = 1'b1;
        step();
        checks++;
        if ({lft_hi, lft_lo, rght_hi, rght_lo, ovr_i_shtdwn} !== 5'b00000) begin
            failures++;
            $display("FAIL midperiod_reset: got %b expected 00000", {lft_hi, lft_lo, rght_hi, rght_lo, ovr_i_shtdwn});
        end
        rst = 1'b0;
    endtask

    // Left at spd 0 (50%); right changes 0 -> 0x400 mid-period 0 and must only take effect in period 1.
    task automatic test_duty_and_shadow();
        int r_hi0, r_hi1, l_hi, l_lo, l_off, ovl, l_first, l_last;
        r_hi0 = 0; r_hi1 = 0; l_hi = 0; l_lo = 0; l_off = 0; ovl = 0; l_first = -1; l_last = -1;
        lft_spd = 12'h000; rght_spd = 12'h000; ovr_i_lft = 1'b0; ovr_i_rght = 1'b0;
        do_reset();
        for (int i = 0; i < 4096; i++) begin
            if (rght_hi) r_hi0++;
            if ((lft_hi && lft_lo) || (rght_hi && rght_lo)) ovl++;
            if (i == 1000) rght_spd = 12'h400;
            step();
        end
        for (int i = 0; i < 4096; i++) begin
            if (rght_hi) r_hi1++;
            if (lft_hi) begin
                l_hi++;
                if (l_first < 0) l_first = i;
                l_last = i;
            end
            if (lft_lo) l_lo++;
            if (!lft_hi && !lft_lo) l_off++;
            if ((lft_hi && lft_lo) || (rght_hi && rght_lo)) ovl++;
            step();
        end
        checks++;
        if (r_hi0 !== 2016) begin failures++; $display("FAIL shadow_cur_period_rhi: got %0d expected 2016", r_hi0); end
        checks++;
        if (r_hi1 !== 3040) begin failures++; $display("FAIL shadow_next_period_rhi: got %0d expected 3040", r_hi1); end
        checks++;
        if (l_hi !== 2016) begin failures++; $display("FAIL half_lhi_count: got %0d expected 2016", l_hi); end
        checks++;
        if (l_lo !== 2016) begin failures++; $display("FAIL half_llo_count: got %0d expected 2016", l_lo); end
        checks++;
        if (l_off !== 64) begin failures++; $display("FAIL half_both_low: got %0d expected 64", l_off); end
        checks++;
        if (l_first !== 34) begin failures++; $display("FAIL half_hi_first: got %0d expected 34", l_first); end
        checks++;
        if (l_last !== 2049) begin failures++; $display("FAIL half_hi_last: got %0d expected 2049", l_last); end
        checks++;
        if (ovl !== 0) begin failures++; $display("FAIL half_overlap: got %0d expected 0", ovl); end
    endtask

    // Left at -2048 (duty 0), right at 2047 (duty 4095); window is a steady 4096 cycles from k=4196.
    task automatic test_duty_extremes();
        int l_hi, l_lo, r_hi, r_lo, ovl, run, max_run;
        l_hi = 0; l_lo = 0; r_hi = 0; r_lo = 0; ovl = 0; run = 0; max_run = 0;
        lft_spd = 12'h800; rght_spd = 12'h7FF; ovr_i_lft = 1'b0; ovr_i_rght = 1'b0;
        do_reset();
        repeat (4196) step();
        for (int i = 0; i < 4096; i++) begin
            if (lft_hi) l_hi++;
            if (lft_lo) l_lo++;
            if (rght_lo) r_lo++;
            if (rght_hi) begin
                r_hi++;
                run = 0;
            end else begin
                run++;
                if (run > max_run) max_run = run;
            end
            if ((lft_hi && lft_lo) || (rght_hi && rght_lo)) ovl++;
            step();
        end
        checks++;
        if (l_hi !== 0) begin failures++; $display("FAIL min_duty_lhi: got %0d expected 0", l_hi); end
        checks++;
        if (l_lo !== 4096) begin failures++; $display("FAIL min_duty_llo: got %0d expected 4096", l_lo); end
        checks++;
        if (r_lo !== 0) begin failures++; $display("FAIL max_duty_rlo: got %0d expected 0", r_lo); end
        checks++;
        if (r_hi !== 4063) begin failures++; $display("FAIL max_duty_rhi: got %0d expected 4063", r_hi); end
        checks++;
        if (max_run !== 33) begin failures++; $display("FAIL max_duty_hi_gap: got %0d expected 33", max_run); end
        checks++;
        if (ovl !== 0) begin failures++; $display("FAIL extremes_overlap: got %0d expected 0", ovl); end
    endtask

    // One blanked period, seven valid periods, one clean period, then held over-current until shutdown.
    task automatic test_ovr();
        int c, shut_seen, bad;
        shut_seen = 0; bad = 0;
        lft_spd = 12'h000; rght_spd = 12'h000; ovr_i_lft = 1'b0; ovr_i_rght = 1'b0;
        do_reset();
        for (int k = 0; k < 32768; k++) begin
            c = k % 4096;
            if (k < 4096) ovr_i_lft = (c >= 5 && c <= 20);
            else          ovr_i_lft = (c >= 100 && c <= 200);
            if (ovr_i_shtdwn) shut_seen++;
            step();
        end
        ovr_i_lft = 1'b0;
        checks++;
        if (int'(dut.ovr_cnt_q) !== 7) begin failures++; $display("FAIL ovr_cnt_after_7: got %0d expected 7", int'(dut.ovr_cnt_q)); end
        for (int k = 0; k < 4096; k++) begin
            if (ovr_i_shtdwn) shut_seen++;
            step();
        end
        checks++;
        if (int'(dut.ovr_cnt_q) !== 0) begin failures++; $display("FAIL ovr_cnt_after_clean: got %0d expected 0", int'(dut.ovr_cnt_q)); end
        checks++;
        if (shut_seen !== 0) begin failures++; $display("FAIL no_early_shutdown: got %0d expected 0", shut_seen); end

        ovr_i_lft = 1'b1;
        for (int k = 0; k < 32767; k++) begin
            if (ovr_i_shtdwn) shut_seen++;
            step();
        end
        checks++;
        if ({ovr_i_shtdwn, lft_lo, rght_lo} !== 3'b011 || shut_seen !== 0) begin
            failures++;
            $display("FAIL pre_8th_wrap: got shtdwn/llo/rlo %b early=%0d expected 011 early=0", {ovr_i_shtdwn, lft_lo, rght_lo}, shut_seen);
        end
        step();
        checks++;
        if ({ovr_i_shtdwn, lft_hi, lft_lo, rght_hi, rght_lo} !== 5'b10000) begin
            failures++;
            $display("FAIL shutdown_8th_wrap: got %b expected 10000", {ovr_i_shtdwn, lft_hi, lft_lo, rght_hi, rght_lo});
        end
        ovr_i_lft = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (!ovr_i_shtdwn || lft_hi || lft_lo || rght_hi || rght_lo) bad++;
            step();
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL shutdown_sticky: got %0d bad cycles expected 0", bad); end
        do_reset();
        checks++;
        if (ovr_i_shtdwn !== 1'b0) begin failures++; $display("FAIL shutdown_cleared_by_rst: got %b expected 0", ovr_i_shtdwn); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        lft_spd = 12'h000;
        rght_spd = 12'h000;
        ovr_i_lft = 1'b0;
        ovr_i_rght = 1'b0;
        test_reset();
        test_duty_and_shadow();
        test_duty_extremes();
        test_ovr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
